// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory-instruction sequencer:
// operation / register encodings, per-operation step counts and the
// step windows in which each strobe is active.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_LDM1  = 2'd2,
    OP_LDM2  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    REG_A = 2'd0,
    REG_B = 2'd1,
    REG_C = 2'd2,
    REG_D = 2'd3
  } reg_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [3:0] step_t;

  // Number of steps each operation spends in RUN
  localparam step_t STEPS_LOAD  = 4'd8;
  localparam step_t STEPS_STORE = 4'd8;
  localparam step_t STEPS_LDM   = 4'd6;

  // LOAD windows: address select wraps the read, read wraps the register load
  localparam step_t LOAD_SELM_LO  = 4'd2;
  localparam step_t LOAD_SELM_HI  = 4'd6;
  localparam step_t LOAD_READ_LO  = 4'd3;
  localparam step_t LOAD_READ_HI  = 4'd6;
  localparam step_t LOAD_LDREG_LO = 4'd4;
  localparam step_t LOAD_LDREG_HI = 4'd5;

  // STORE windows: address select and register drive wrap the write
  localparam step_t STORE_SELM_LO   = 4'd2;
  localparam step_t STORE_SELM_HI   = 4'd6;
  localparam step_t STORE_SELREG_LO = 4'd3;
  localparam step_t STORE_SELREG_HI = 4'd6;
  localparam step_t STORE_WRITE_LO  = 4'd4;
  localparam step_t STORE_WRITE_HI  = 4'd5;

  // LDM1/LDM2 windows: register drive wraps the single-cycle address load
  localparam step_t LDM_SELREG_LO = 4'd2;
  localparam step_t LDM_SELREG_HI = 4'd4;
  localparam step_t LDM_LOAD_LO   = 4'd3;
  localparam step_t LDM_LOAD_HI   = 4'd3;

  function automatic step_t op_steps(input op_e op);
    case (op)
      OP_LOAD:  return STEPS_LOAD;
      OP_STORE: return STEPS_STORE;
      default:  return STEPS_LDM;
    endcase
  endfunction

  function automatic logic in_window(input step_t s, input step_t lo, input step_t hi);
    return (s >= lo) && (s <= hi);
  endfunction

endpackage

// File: rtl/mem_sequencer_counter.sv
// Step counter for the sequencer: cleared on reset or on leaving RUN,
// loaded with 1 on entry to RUN, advanced only when asked, and flags
// when the current step equals the operation's final step.
module seq_step_counter
  import mem_seq_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  load_first,
  input  logic  advance,
  input  step_t limit,
  output step_t count,
  output logic  at_limit
);

  // Step register: clear wins over load, load wins over advance, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load_first) begin
      count <= 4'd1;
    end else if (advance) begin
      count <= count + 4'd1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/mem_sequencer.sv
// Memory-class instruction sequencer. Captures an operation and register
// index on start, steps through a fixed sequence of strobes while step_en
// allows, pulses done, then returns to idle. Outputs decode only registered
// state, so no input reaches an output combinationally.
module mem_sequencer
  import mem_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step_en,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [1:0] rsel,
  output logic       ldM1,
  output logic       ldM2,
  output logic       selM,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] ld_reg,
  output logic [3:0] sel_reg,
  output logic       busy,
  output logic       done
);

  state_e   state;
  state_e   state_next;
  op_e      op_q;
  reg_idx_e rsel_q;
  logic     capture;
  logic     cnt_clear;
  logic     cnt_first;
  logic     cnt_adv;
  step_t    s;
  logic     s_last;
  logic [3:0] reg_onehot;

  seq_step_counter u_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .load_first (cnt_first),
    .advance    (cnt_adv),
    .limit      (op_steps(op_q)),
    .count      (s),
    .at_limit   (s_last)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operation and register index are latched only when a start is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_LOAD;
      rsel_q <= REG_A;
    end else if (capture) begin
      op_q   <= op_e'(op);
      rsel_q <= reg_idx_e'(rsel);
    end
  end

  // Next-state and counter control; every transition waits for step_en
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_first  = 1'b0;
    cnt_adv    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (step_en && start) begin
          state_next = ST_RUN;
          capture    = 1'b1;
          cnt_first  = 1'b1;
        end
      end
      ST_RUN: begin
        if (step_en) begin
          if (s_last) begin
            state_next = ST_DONE;
            cnt_clear  = 1'b1;
          end else begin
            cnt_adv = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (step_en) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  assign reg_onehot = 4'b0001 << rsel_q;

  // Strobe decode from the registered state, step and captured operation
  always_comb begin
    ldM1      = 1'b0;
    ldM2      = 1'b0;
    selM      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ld_reg    = 4'b0000;
    sel_reg   = 4'b0000;
    busy      = (state == ST_RUN);
    done      = (state == ST_DONE);
    if (state == ST_RUN) begin
      case (op_q)
        OP_LOAD: begin
          selM     = in_window(s, LOAD_SELM_LO, LOAD_SELM_HI);
          mem_read = in_window(s, LOAD_READ_LO, LOAD_READ_HI);
          if (in_window(s, LOAD_LDREG_LO, LOAD_LDREG_HI)) begin
            ld_reg = reg_onehot;
          end
        end
        OP_STORE: begin
          selM      = in_window(s, STORE_SELM_LO, STORE_SELM_HI);
          mem_write = in_window(s, STORE_WRITE_LO, STORE_WRITE_HI);
          if (in_window(s, STORE_SELREG_LO, STORE_SELREG_HI)) begin
            sel_reg = reg_onehot;
          end
        end
        OP_LDM1: begin
          ldM1 = in_window(s, LDM_LOAD_LO, LDM_LOAD_HI);
          if (in_window(s, LDM_SELREG_LO, LDM_SELREG_HI)) begin
            sel_reg = reg_onehot;
          end
        end
        default: begin
          ldM2 = in_window(s, LDM_LOAD_LO, LDM_LOAD_HI);
          if (in_window(s, LDM_SELREG_LO, LDM_SELREG_HI)) begin
            sel_reg = reg_onehot;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: full LOAD / STORE / LDM2 runs,
// a step_en freeze, an asynchronous reset mid-STORE and a start held
// high across an LDM1, all against hand-derived step windows.
module tb_mem_sequencer;

  logic       clk;
  logic       reset;
  logic       step_en;
  logic       start;
  logic [1:0] op;
  logic [1:0] rsel;
  logic       ldM1;
  logic       ldM2;
  logic       selM;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] ld_reg;
  logic [3:0] sel_reg;
  logic       busy;
  logic       done;
  logic [14:0] obs;

  int n_compared;
  int n_mismatched;

  // Vector layout: {busy, done, selM, mem_read, mem_write, ldM1, ldM2, ld_reg, sel_reg}
  localparam logic [14:0] IDLE_VEC = 15'h0000;
  localparam logic [14:0] DONE_VEC = 15'h2000;

  mem_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .step_en   (step_en),
    .start     (start),
    .op        (op),
    .rsel      (rsel),
    .ldM1      (ldM1),
    .ldM2      (ldM2),
    .selM      (selM),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ld_reg    (ld_reg),
    .sel_reg   (sel_reg),
    .busy      (busy),
    .done      (done)
  );

  assign obs = {busy, done, selM, mem_read, mem_write, ldM1, ldM2, ld_reg, sel_reg};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [14:0] expect_run(input int o, input int r, input int c);
    logic       sm;
    logic       rd;
    logic       wr;
    logic       m1;
    logic       m2;
    logic [3:0] ldr;
    logic [3:0] slr;
    logic [3:0] oh;
    sm  = 1'b0;
    rd  = 1'b0;
    wr  = 1'b0;
    m1  = 1'b0;
    m2  = 1'b0;
    ldr = 4'b0000;
    slr = 4'b0000;
    oh  = 4'b0001 << r;
    case (o)
      0: begin
        sm = (c >= 2 && c <= 6);
        rd = (c >= 3 && c <= 6);
        if (c >= 4 && c <= 5) ldr = oh;
      end
      1: begin
        sm = (c >= 2 && c <= 6);
        wr = (c >= 4 && c <= 5);
        if (c >= 3 && c <= 6) slr = oh;
      end
      default: begin
        m1 = (o == 2) && (c == 3);
        m2 = (o == 3) && (c == 3);
        if (c >= 2 && c <= 4) slr = oh;
      end
    endcase
    return {1'b1, 1'b0, sm, rd, wr, m1, m2, ldr, slr};
  endfunction

  task automatic applyStimulus(input logic st, input logic [1:0] o,
                               input logic [1:0] r, input logic se);
    start   = st;
    op      = o;
    rsel    = r;
    step_en = se;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] expected);
    n_compared++;
    assert (obs === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expected);
    end
  endtask

  task automatic checkCount(input string tag, input int observed, input int expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence
  initial begin
    int busy_cycles;
    int done_pulses;
    n_compared   = 0;
    n_mismatched = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0);
    #1;
    checkOutput("reset_async", IDLE_VEC);
    tick();
    checkOutput("reset_held", IDLE_VEC);

    // LOAD into C
    reset = 1'b0;
    applyStimulus(1'b1, 2'd0, 2'd2, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checkOutput($sformatf("load_c%0d", c), expect_run(0, 2, c));
      if (c == 4) checkCount("load_ldreg_c4", int'(ld_reg), 4);
      tick();
    end
    checkOutput("load_done_c9", DONE_VEC);
    tick();
    checkOutput("load_idle", IDLE_VEC);

    // STORE from A
    applyStimulus(1'b1, 2'd1, 2'd0, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checkOutput($sformatf("store_c%0d", c), expect_run(1, 0, c));
      tick();
    end
    checkOutput("store_done", DONE_VEC);
    tick();
    checkOutput("store_idle", IDLE_VEC);

    // LDM2 from D
    applyStimulus(1'b1, 2'd3, 2'd3, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checkOutput($sformatf("ldm2_c%0d", c), expect_run(3, 3, c));
      tick();
    end
    checkOutput("ldm2_done_c7", DONE_VEC);
    tick();
    checkOutput("ldm2_idle", IDLE_VEC);

    // LOAD into B with step_en dropped for three edges at step 4
    busy_cycles = 0;
    done_pulses = 0;
    applyStimulus(1'b1, 2'd0, 2'd1, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("frz_c%0d", c), expect_run(0, 1, c));
      busy_cycles += int'(busy);
      done_pulses += int'(done);
      if (c < 4) tick();
    end
    step_en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("frz_hold%0d", k), expect_run(0, 1, 4));
      busy_cycles += int'(busy);
      done_pulses += int'(done);
    end
    step_en = 1'b1;
    for (int c = 5; c <= 8; c++) begin
      tick();
      checkOutput($sformatf("frz_c%0d", c), expect_run(0, 1, c));
      busy_cycles += int'(busy);
      done_pulses += int'(done);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      busy_cycles += int'(busy);
      done_pulses += int'(done);
    end
    checkOutput("frz_idle", IDLE_VEC);
    checkCount("frz_busy_cycles", busy_cycles, 11);
    checkCount("frz_done_pulses", done_pulses, 1);

    // STORE from C, reset asserted while the write strobe is high
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("rst_store_c%0d", c), expect_run(1, 2, c));
      if (c < 5) tick();
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_async", IDLE_VEC);
    tick();
    checkOutput("rst_mid_held", IDLE_VEC);
    reset = 1'b0;

    // LDM1 from B with start held high throughout
    applyStimulus(1'b1, 2'd2, 2'd1, 1'b1);
    tick();
    for (int c = 1; c <= 6; c++) begin
      checkOutput($sformatf("ldm1_c%0d", c), expect_run(2, 1, c));
      tick();
    end
    checkOutput("ldm1_done", DONE_VEC);
    tick();
    checkOutput("ldm1_gap_idle", IDLE_VEC);
    tick();
    checkOutput("ldm1_again_c1", expect_run(2, 1, 1));
    start = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      checkOutput($sformatf("ldm1_again_c%0d", c), expect_run(2, 1, c));
    end
    tick();
    checkOutput("ldm1_again_done", DONE_VEC);
    tick();
    checkOutput("ldm1_again_idle", IDLE_VEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
